spi_cmd_sequencer: RTL

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/spi_pkg.sv | 23 ++
 rtl/cmd_fifo.sv | 70 +++++++
 rtl/spi_cmd_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI command sequencer: FSM state encoding,
// timing defaults and a helper that sizes the shared cycle counter.
package spi_pkg;

    localparam int WORD_W = 16;

    localparam int GAP_CYCLES_DEFAULT  = 16;
    localparam int ACK_TIMEOUT_DEFAULT = 255;

    // State encoding kept as plain constants so legacy code can compare against them.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_XFER = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Width of one counter able to hold the larger of the gap and ack-timeout limits.
    function automatic int cnt_width(input int gap, input int ack);
        return $clog2(((gap > ack) ? gap : ack) + 1);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular first-word-fall-through command FIFO. The head word is always
// visible on rd_data; a write is dropped (and overflow latched) only when
// the FIFO is full and no pop happens in the same cycle.
module cmd_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     CLK100MHZ,
    input  logic                     ser_cnt_reset,
    input  logic                     wr_en,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic                     flush,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Word storage.
    // NOTE: the array has no reset; stale entries are never visible because level gates every read.
    always_ff @(posedge CLK100MHZ) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag; pointers wrap naturally at DEPTH.
    // NOTE: state is updated with <= so every register sees the pre-edge values of the others.
    always_ff @(posedge CLK100MHZ or posedge ser_cnt_reset) begin
        if (ser_cnt_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level <= level + 1'b1;
                else if (pop && !push) level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Drains queued 16-bit command words to a downstream serializer, one frame
// per word, with a request/ack handshake on ser_enable / ser_ld_n, a fixed
// idle gap after each frame and an ack timeout that aborts the drain.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                     CLK100MHZ,
    input  logic                     ser_cnt_reset,
    input  logic                     wr_en,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     start,
    input  logic                     ser_ld_n,
    output logic                     ser_enable,
    output logic [WORD_W-1:0]        ser_data,
    output logic                     busy,
    output logic                     done,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = cnt_width(GAP_CYCLES, ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              load_word;
    logic              set_timeout;
    logic              word_remains;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK100MHZ     (CLK100MHZ),
        .ser_cnt_reset (ser_cnt_reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_en         (fifo_pop),
        .flush         (fifo_flush),
        .rd_data       (fifo_head),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow)
    );

    // A word is still pending after the GAP pop if more than one is held, or one is
    // being pushed right now (the pop frees a slot, so that push is always accepted).
    assign word_remains = (level[LW-1:1] != '0) || wr_en;

    assign ser_enable = (state == ST_REQ);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // Next-state, counter and FIFO-control decode.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        load_word   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = empty ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                load_word = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!ser_ld_n) begin
                    state_nxt = ST_XFER;
                end else if (cnt == ACK_LAST) begin
                    set_timeout = 1'b1;
                    fifo_flush  = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_XFER: begin
                if (ser_ld_n) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    fifo_pop  = 1'b1;
                    state_nxt = word_remains ? ST_LOAD : ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, shared counter, held serializer word and sticky timeout flag.
    always_ff @(posedge CLK100MHZ or posedge ser_cnt_reset) begin
        if (ser_cnt_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ser_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_word)   ser_data    <= fifo_head;
            if (set_timeout) timeout_err <= 1'b1;
        end
    end

endmodule
